io_irq_bank: RTL and testbench
==============================

Name: io_irq_bank

Overview:
- Parametrised I/O port bank with an integrated interrupt controller for the next-generation cpu top.
- Replaces the fixed four 8-bit input ports, the fixed four 8-bit output ports and the single external interrupt line.
- Provides N_PORTS input/output ports of WIDTH bits, plus per-port change-detect interrupts with a mask and fixed priority.
- Drives a request/acknowledge/return handshake with the control unit and supplies a port vector.

Parameters:
- WIDTH, 8, bit width of each port.
- N_PORTS, 4, number of input ports and number of output ports (2..16).
- ADDR_W, $clog2(N_PORTS), width of the port select and of the vector.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- e_in  in  N_PORTS*WIDTH  external inputs; port i is bits [i*WIDTH +: WIDTH].
- s_out  out  N_PORTS*WIDTH  registered external outputs; same packing as e_in.
- addr  in  ADDR_W  port select for both read and write.
- rd_data  out  WIDTH  synchronised value of input port addr.
- we  in  1  write strobe; stores wr_data into output port addr.
- wr_data  in  WIDTH  output write data.
- mask_we  in  1  write strobe for the interrupt mask.
- mask_data  in  N_PORTS  new mask value; bit i = 1 enables port i.
- irq_req  out  1  interrupt request to the control unit.
- irq_vec  out  ADDR_W  index of the port being serviced.
- irq_ack  in  1  control unit accepts the request.
- irq_ret  in  1  control unit finished the handler.
- irq_pending  out  N_PORTS  pending flags, for debug and status reads.

Behaviour:
- Reset is asynchronous. While reset is high, all of the following are 0:
  - s_out, all synchroniser and previous-value registers, mask, irq_pending, irq_vec;
  - irq_req; the state machine is held in IDLE.
- Reset asserted mid-operation aborts everything; no pending event survives reset.
- Input path, per port: two-flop synchroniser (sync1, sync2), then a prev register that follows sync2 each cycle.
  - rd_data = sync2[addr], combinational from the registers.
  - An e_in change that is stable before edge t appears on rd_data after edge t+1.
- Change event for port i: sync2 != prev, with any bit differing; the event is visible in the cycle after edge t+1.
- irq_pending[i] is set at the next edge (t+2) only if mask[i]=1. Masked events are discarded, not deferred.
- Output path: we=1 at an edge loads wr_data into s_out[addr] at that edge; all other ports hold.
- Simultaneous we and a read of the same addr are independent, because inputs and outputs are separate ports.
- Mask: mask_we=1 loads mask_data at the edge. Clearing a mask bit does not clear an already-set pending bit.
- State machine states: IDLE, REQ, SERVICE. irq_req = (state==REQ), registered.
  - IDLE: if any irq_pending bit is set, latch irq_vec = the lowest set index (port 0 has the highest priority) and move to REQ at the next edge.
  - REQ: irq_vec is frozen. On irq_ack=1, clear irq_pending[irq_vec] and move to SERVICE at the same edge.
  - SERVICE: on irq_ret=1, move to IDLE. Minimum one cycle in SERVICE. No nesting.
- Boundary cases:
  - irq_ack in IDLE or SERVICE, and irq_ret in IDLE or REQ, are ignored.
  - irq_ack and irq_ret high together in REQ: only the ack is acted on.
  - Set and clear of the same pending bit at the same edge: set wins.
  - A new change event on port irq_vec while in SERVICE re-pends that port; it is taken after return.
  - Back-to-back: irq_ret at edge n with another bit pending gives irq_req=1 after edge n+1.
  - addr >= N_PORTS (non-power-of-two N_PORTS): reads return 0 and writes are dropped.

Decomposition:
- Shared package cpu_pkg:
  - state enum {IDLE, REQ, SERVICE};
  - a localparam function for the lowest-set-bit priority encode;
  - default WIDTH and N_PORTS constants reused by the cd and uc successors.
- One sub-module, io_sync_edge: WIDTH-bit two-flop synchroniser, prev register and change output.
  - Instantiated N_PORTS times by a generate loop.
- The priority encoder, state machine, mask, pending and output registers live in io_irq_bank.

Test Plan:
- Reset: drive e_in=all 0xFF and assert reset mid-stream.
  - Expected: s_out=0, irq_req=0, irq_pending=0 immediately (asynchronous); rd_data=0xFF two edges after release.
- Output write: we=1, addr=2, wr_data=0xA5; then we=1, addr=3, wr_data=0x3C.
  - Expected: s_out port2=0xA5 and port3=0x3C after their edges; ports 0 and 1 stay 0.
- Single interrupt with latency: mask=4'b0010, e1 changes 0x00->0x01 before edge t.
  - Expected: irq_pending=4'b0010 after t+2; irq_req=1 and irq_vec=1 after t+3.
  - Then irq_ack gives pending=0 and irq_req=0; irq_ret returns the state machine to IDLE.
- Priority and masking: mask=4'b1011, ports 3, 2 and 0 change in the same cycle.
  - Expected: port 2 is never pending; vec=0 is served first, then vec=3 one cycle after irq_ret.
- Collision: in SERVICE for vec=1, port 1 changes again.
  - Expected: pending[1] is re-set; after irq_ret, irq_req=1 with irq_vec=1.
  - Also: ack and a fresh event on the same edge leave pending set.
- Ignored handshakes: irq_ack in IDLE, and irq_ret in REQ.
  - Expected: no state change, no pending cleared, irq_req holds its value.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and helpers for the cpu top: interrupt FSM states, default
// port geometry and the fixed-priority encoder.
package cpu_pkg;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_N_PORTS = 4;
  localparam int MAX_PORTS   = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  // Index of the lowest set bit; bit 0 has the highest priority.
  function automatic logic [3:0] lowest_set(input logic [MAX_PORTS-1:0] v);
    lowest_set = '0;
    for (int i = MAX_PORTS - 1; i >= 0; i--) begin
      if (v[i]) lowest_set = 4'(i);
    end
  endfunction

endpackage

// File: rtl/io_sync_edge.sv
// Two-flop synchroniser for one input port, followed by a previous-value
// register; change flags any bit difference between the two.
module io_sync_edge #(
  parameter int WIDTH = cpu_pkg::DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             change
);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= d;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign q      = sync2;
  assign change = (sync2 != prev);

endmodule

// File: rtl/io_irq_bank.sv
// Parametrised I/O port bank with per-port change-detect interrupts, mask,
// fixed priority and a request/ack/return handshake to the control unit.
module io_irq_bank
  import cpu_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int N_PORTS = DEF_N_PORTS,
  parameter int ADDR_W  = $clog2(N_PORTS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_PORTS*WIDTH-1:0] e_in,
  output logic [N_PORTS*WIDTH-1:0] s_out,
  input  logic [ADDR_W-1:0]        addr,
  output logic [WIDTH-1:0]         rd_data,
  input  logic                     we,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     mask_we,
  input  logic [N_PORTS-1:0]       mask_data,
  output logic                     irq_req,
  output logic [ADDR_W-1:0]        irq_vec,
  input  logic                     irq_ack,
  input  logic                     irq_ret,
  output logic [N_PORTS-1:0]       irq_pending
);

  logic [WIDTH-1:0]   sync_val [N_PORTS];
  logic [N_PORTS-1:0] change;
  logic [N_PORTS-1:0] mask;
  logic [3:0]         first_pending;
  logic               ack_fire;
  state_t             state;
  state_t             state_next;

  for (genvar g = 0; g < N_PORTS; g++) begin : g_port
    io_sync_edge #(.WIDTH(WIDTH)) u_sync (
      .clk    (clk),
      .reset  (reset),
      .d      (e_in[g*WIDTH +: WIDTH]),
      .q      (sync_val[g]),
      .change (change[g])
    );
  end

  // Address decode by equality so out-of-range selects read 0 and drop writes.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      if (addr == ADDR_W'(i)) rd_data = sync_val[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_out <= '0;
      mask  <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        if (we && addr == ADDR_W'(i)) s_out[i*WIDTH +: WIDTH] <= wr_data;
      end
      if (mask_we) mask <= mask_data;
    end
  end

  assign ack_fire      = (state == REQ) && irq_ack;
  assign first_pending = lowest_set(MAX_PORTS'(irq_pending));

  // A masked-in change at the same edge as the ack re-pends the port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_pending <= '0;
    end else begin
      for (int i = 0; i < N_PORTS; i++) begin
        irq_pending[i] <= (change[i] & mask[i]) |
                          (irq_pending[i] & ~(ack_fire && irq_vec == ADDR_W'(i)));
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_vec <= '0;
    end else if (state == IDLE && |irq_pending) begin
      irq_vec <= first_pending[ADDR_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (|irq_pending) state_next = REQ;
      REQ:     if (irq_ack)      state_next = SERVICE;
      SERVICE: if (irq_ret)      state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    irq_req = (state == REQ);
  end

endmodule

// File: tb/tb_io_irq_bank.sv
// Directed bench for io_irq_bank: reset, output writes, interrupt latency,
// priority/masking, collisions and ignored handshakes.
module tb_io_irq_bank;

  localparam int WIDTH   = 8;
  localparam int N_PORTS = 4;
  localparam int ADDR_W  = 2;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [N_PORTS*WIDTH-1:0] e_in;
  logic [N_PORTS*WIDTH-1:0] s_out;
  logic [ADDR_W-1:0]        addr;
  logic [WIDTH-1:0]         rd_data;
  logic                     we;
  logic [WIDTH-1:0]         wr_data;
  logic                     mask_we;
  logic [N_PORTS-1:0]       mask_data;
  logic                     irq_req;
  logic [ADDR_W-1:0]        irq_vec;
  logic                     irq_ack;
  logic                     irq_ret;
  logic [N_PORTS-1:0]       irq_pending;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  io_irq_bank #(.WIDTH(WIDTH), .N_PORTS(N_PORTS), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .e_in        (e_in),
    .s_out       (s_out),
    .addr        (addr),
    .rd_data     (rd_data),
    .we          (we),
    .wr_data     (wr_data),
    .mask_we     (mask_we),
    .mask_data   (mask_data),
    .irq_req     (irq_req),
    .irq_vec     (irq_vec),
    .irq_ack     (irq_ack),
    .irq_ret     (irq_ret),
    .irq_pending (irq_pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_irq(input string tag, input logic req, input logic [ADDR_W-1:0] vec,
                         input logic [N_PORTS-1:0] pend);
    check({tag, "_req"}, 64'(irq_req), 64'(req));
    if (req) check({tag, "_vec"}, 64'(irq_vec), 64'(vec));
    check({tag, "_pend"}, 64'(irq_pending), 64'(pend));
  endtask

  initial begin
    reset = 1'b1; e_in = '0; addr = '0; we = 0; wr_data = '0;
    mask_we = 0; mask_data = '0; irq_ack = 0; irq_ret = 0;
    step(); step();
    check("rst_s_out", 64'(s_out), 64'h0);
    chk_irq("rst", 1'b0, 2'd0, 4'b0000);
    check("rst_rd", 64'(rd_data), 64'h0);

    // Reset asserted mid-stream clears outputs asynchronously
    reset = 1'b0;
    step();
    mask_we = 1; mask_data = 4'b1111; we = 1; addr = 2'd1; wr_data = 8'h55;
    step();
    mask_we = 0; we = 0; e_in = 32'hFFFF_FFFF;
    check("pre_rst_s_out", 64'(s_out), 64'h0000_5500);
    step();
    #2 reset = 1'b1;
    #1;
    check("async_s_out", 64'(s_out), 64'h0);
    chk_irq("async", 1'b0, 2'd0, 4'b0000);
    step(); step();
    reset = 1'b0; addr = 2'd0;
    step();
    check("rel_rd_1", 64'(rd_data), 64'h00);
    step();
    check("rel_rd_2", 64'(rd_data), 64'hFF);
    step(); step();
    chk_irq("rel_mask0", 1'b0, 2'd0, 4'b0000);
    e_in = '0;
    step(); step(); step(); step();
    check("settle_rd", 64'(rd_data), 64'h00);
    chk_irq("settle", 1'b0, 2'd0, 4'b0000);

    // Output writes
    we = 1; addr = 2'd2; wr_data = 8'hA5;
    step();
    check("wr_p2", 64'(s_out), 64'h00A5_0000);
    addr = 2'd3; wr_data = 8'h3C;
    step();
    we = 0;
    check("wr_p3", 64'(s_out), 64'h3CA5_0000);
    step();
    check("wr_hold", 64'(s_out), 64'h3CA5_0000);

    // Single interrupt with latency
    mask_we = 1; mask_data = 4'b0010;
    step();
    mask_we = 0; addr = 2'd1; e_in = 32'h0000_0100;
    step();
    chk_irq("lat_t", 1'b0, 2'd0, 4'b0000);
    step();
    chk_irq("lat_t1", 1'b0, 2'd0, 4'b0000);
    check("lat_rd", 64'(rd_data), 64'h01);
    step();
    chk_irq("lat_t2", 1'b0, 2'd0, 4'b0010);
    step();
    chk_irq("lat_t3", 1'b1, 2'd1, 4'b0010);
    irq_ret = 1;
    step();
    irq_ret = 0;
    chk_irq("ret_in_req", 1'b1, 2'd1, 4'b0010);
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk_irq("ack1", 1'b0, 2'd1, 4'b0000);

    // Collision: port 1 changes again while in SERVICE
    e_in = 32'h0000_0200;
    step(); step(); step();
    chk_irq("coll_pend", 1'b0, 2'd1, 4'b0010);
    irq_ret = 1;
    step();
    irq_ret = 0;
    chk_irq("coll_ret", 1'b0, 2'd1, 4'b0010);
    step();
    chk_irq("coll_req", 1'b1, 2'd1, 4'b0010);

    // Ack and a fresh event on the same edge: set wins
    e_in = 32'h0000_0300;
    step(); step();
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk_irq("ack_set", 1'b0, 2'd1, 4'b0010);
    irq_ret = 1;
    step();
    irq_ret = 0;
    step();
    chk_irq("ack_set_req", 1'b1, 2'd1, 4'b0010);
    irq_ack = 1;
    step();
    irq_ack = 0;
    irq_ret = 1;
    step();
    irq_ret = 0;
    chk_irq("drained", 1'b0, 2'd1, 4'b0000);

    // Ack in IDLE is ignored
    irq_ack = 1;
    step(); step();
    irq_ack = 0;
    chk_irq("ack_idle", 1'b0, 2'd1, 4'b0000);

    // Priority and masking
    mask_we = 1; mask_data = 4'b1011;
    step();
    mask_we = 0; addr = 2'd2; e_in = 32'h1122_0333;
    step(); step(); step();
    chk_irq("prio_pend", 1'b0, 2'd1, 4'b1001);
    check("prio_rd2", 64'(rd_data), 64'h22);
    mask_we = 1; mask_data = 4'b0000;
    step();
    mask_we = 0;
    chk_irq("prio_req0", 1'b1, 2'd0, 4'b1001);
    irq_ack = 1;
    step();
    irq_ack = 0;
    chk_irq("prio_ack0", 1'b0, 2'd0, 4'b1000);
    irq_ret = 1;
    step();
    irq_ret = 0;
    step();
    chk_irq("prio_req3", 1'b1, 2'd3, 4'b1000);
    irq_ack = 1;
    step();
    irq_ack = 0;
    irq_ret = 1;
    step();
    irq_ret = 0;
    step(); step();
    chk_irq("prio_done", 1'b0, 2'd3, 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
